// File: rtl/dtw_src_writer.sv
// Producer for the DTW source FIFO: one AXI-Stream frame (query words then reference words) per search.
// Latency: stream-to-FIFO write is combinational (same cycle); status pulses and counters register one cycle later.
// Backpressure: tready drops whenever the FIFO is full or the block is not accepting; FLUSH drains without writing.
module dtw_src_writer #(
  parameter int SQG_LEN = 250,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       reference_len,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic              fifo_wren,
  output logic [DATA_W-1:0] fifo_wdata,
  input  logic              fifo_full,
  input  logic              fifo_clear,
  output logic              core_rs,
  input  logic              core_running,
  input  logic              core_done,
  output logic              busy,
  output logic              frame_done,
  output logic              err_short,
  output logic              err_long,
  output logic              err_cfg,
  output logic [31:0]       words_written
);

  typedef enum logic [2:0] {IDLE, QUERY, REF, FLUSH, WAIT_CORE} state_t;

  localparam logic [31:0] Q_LAST = 32'(SQG_LEN - 1);

  state_t      state, state_d;
  logic [31:0] q_cnt, r_cnt, ref_len;
  logic [31:0] ref_last;
  logic        xfer, in_data;
  logic        start_ok, cfg_d, short_d, long_d, done_d;

  assign in_data       = (state == QUERY) || (state == REF);
  assign s_axis_tready = (in_data && !fifo_full) || (state == FLUSH);
  assign xfer          = s_axis_tvalid && s_axis_tready;
  assign fifo_wren     = xfer && in_data;
  assign fifo_wdata    = s_axis_tdata;
  assign busy          = (state != IDLE);
  assign ref_last      = ref_len - 32'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and event decode; fifo_clear aborts any accepting state and pre-empts other transitions.
  always_comb begin
    state_d  = state;
    start_ok = 1'b0;
    cfg_d    = 1'b0;
    short_d  = 1'b0;
    long_d   = 1'b0;
    done_d   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (reference_len != 32'd0) begin
            start_ok = 1'b1;
            state_d  = QUERY;
          end else begin
            cfg_d = 1'b1;
          end
        end
      end
      QUERY: begin
        if (fifo_clear) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else if (xfer) begin
          if (s_axis_tlast) begin
            short_d = 1'b1;
            state_d = IDLE;
          end else if (q_cnt == Q_LAST) begin
            state_d = REF;
          end
        end
      end
      REF: begin
        if (fifo_clear) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else if (xfer) begin
          if (r_cnt == ref_last) begin
            if (s_axis_tlast) begin
              state_d = WAIT_CORE;
            end else begin
              long_d  = 1'b1;
              state_d = FLUSH;
            end
          end else if (s_axis_tlast) begin
            short_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (fifo_clear) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else if (xfer && s_axis_tlast) begin
          state_d = WAIT_CORE;
        end
      end
      WAIT_CORE: begin
        if (core_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame counters and latched reference length; counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_cnt         <= 32'd0;
      r_cnt         <= 32'd0;
      ref_len       <= 32'd0;
      words_written <= 32'd0;
    end else if (start_ok) begin
      q_cnt         <= 32'd0;
      r_cnt         <= 32'd0;
      ref_len       <= reference_len;
      words_written <= 32'd0;
    end else begin
      if (xfer && (state == QUERY) && (q_cnt != 32'hFFFF_FFFF)) q_cnt <= q_cnt + 32'd1;
      if (xfer && (state == REF) && (r_cnt != 32'hFFFF_FFFF))   r_cnt <= r_cnt + 32'd1;
      if (fifo_wren && (words_written != 32'hFFFF_FFFF))        words_written <= words_written + 32'd1;
    end
  end

  // Run/stop request: raised on an accepted start, dropped once the core reports running or the frame ends.
  always_ff @(posedge clk) begin
    if (rst)                                 core_rs <= 1'b0;
    else if (start_ok)                       core_rs <= 1'b1;
    else if (core_running || state_d == IDLE) core_rs <= 1'b0;
  end

  // One-cycle status pulses, registered from the decoded events.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      err_cfg    <= 1'b0;
    end else begin
      frame_done <= done_d;
      err_short  <= short_d;
      err_long   <= long_d;
      err_cfg    <= cfg_d;
    end
  end

endmodule

// File: tb/tb_dtw_src_writer.sv
// Directed bench for dtw_src_writer with SQG_LEN=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there or on the falling edge.
// A falling-edge monitor logs every FIFO write for ordering checks.
module tb_dtw_src_writer;

  logic        clk, rst, start;
  logic [31:0] reference_len;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic        fifo_wren;
  logic [31:0] fifo_wdata;
  logic        fifo_full, fifo_clear;
  logic        core_rs, core_running, core_done;
  logic        busy, frame_done, err_short, err_long, err_cfg;
  logic [31:0] words_written;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] wr_log[$];

  dtw_src_writer #(.SQG_LEN(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .reference_len(reference_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .fifo_wren(fifo_wren), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .fifo_clear(fifo_clear), .core_rs(core_rs), .core_running(core_running),
    .core_done(core_done), .busy(busy), .frame_done(frame_done),
    .err_short(err_short), .err_long(err_long), .err_cfg(err_cfg),
    .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (fifo_wren === 1'b1) wr_log.push_back(fifo_wdata);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] len);
    start = 1'b1;
    reference_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bit got;
    got = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (s_axis_tready === 1'b1) got = 1'b1;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL send_timeout: word %0h never accepted (ready=%b), required accept within 50 cycles", d, s_axis_tready);
    end
  endtask

  task automatic send_range(input int first, input int last_w, input int tlast_at);
    for (int w = first; w <= last_w; w++) send_word(32'(w), (w == tlast_at));
  endtask

  task automatic finish_frame(input string tag);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    n_checks++;
    if (frame_done !== 1'b1) begin n_fail++; $display("FAIL %s_frame_done: got %b want 1", tag, frame_done); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_after_done: busy got %b want 0", tag, busy); end
    n_checks++;
    if (core_rs !== 1'b0) begin n_fail++; $display("FAIL %s_rs_after_done: got %b want 0", tag, core_rs); end
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL %s_done_single_pulse: got %b want 0", tag, frame_done); end
    core_running = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({core_rs, busy, frame_done, err_short, err_long, err_cfg} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: rs/busy/done/short/long/cfg got %b want 000000",
               {core_rs, busy, frame_done, err_short, err_long, err_cfg});
    end
    n_checks++;
    if (words_written !== 32'd0) begin n_fail++; $display("FAIL reset_words: got %0d want 0", words_written); end
    n_checks++;
    if ({s_axis_tready, fifo_wren} !== 2'b00) begin n_fail++; $display("FAIL reset_stream: tready/wren got %b want 00", {s_axis_tready, fifo_wren}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    wr_log.delete();
    do_start(32'd6);
    n_checks++;
    if (core_rs !== 1'b1) begin n_fail++; $display("FAIL basic_rs_set: got %b want 1", core_rs); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
    tick();
    tick();
    core_running = 1'b1;
    n_checks++;
    if (core_rs !== 1'b1) begin n_fail++; $display("FAIL basic_rs_hold: got %b want 1", core_rs); end
    tick();
    n_checks++;
    if (core_rs !== 1'b0) begin n_fail++; $display("FAIL basic_rs_clear: got %b want 0", core_rs); end
    send_range(1, 10, 10);
    n_checks++;
    if (words_written !== 32'd10) begin n_fail++; $display("FAIL basic_words: got %0d want 10", words_written); end
    n_checks++;
    if ({busy, s_axis_tready, core_rs} !== 3'b100) begin
      n_fail++; $display("FAIL basic_wait_core: busy/tready/rs got %b want 100", {busy, s_axis_tready, core_rs});
    end
    n_checks++;
    if (wr_log.size() != 10) begin n_fail++; $display("FAIL basic_log_size: got %0d want 10", wr_log.size()); end
    for (int i = 0; i < wr_log.size() && i < 10; i++) begin
      n_checks++;
      if (wr_log[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL basic_order[%0d]: got %0h want %0h", i, wr_log[i], i + 1); end
    end
    finish_frame("basic");
  endtask

  task automatic test_stall();
    wr_log.delete();
    do_start(32'd6);
    send_range(1, 3, 10);
    fifo_full     = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'd4;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if ({s_axis_tready, fifo_wren} !== 2'b00) begin
        n_fail++; $display("FAIL stall_cycle%0d: tready/wren got %b want 00", c, {s_axis_tready, fifo_wren});
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (words_written !== 32'd3) begin n_fail++; $display("FAIL stall_hold_words: got %0d want 3", words_written); end
    fifo_full = 1'b0;
    send_range(4, 10, 10);
    n_checks++;
    if (words_written !== 32'd10) begin n_fail++; $display("FAIL stall_words: got %0d want 10", words_written); end
    n_checks++;
    if (wr_log.size() != 10) begin n_fail++; $display("FAIL stall_log_size: got %0d want 10", wr_log.size()); end
    for (int i = 0; i < wr_log.size() && i < 10; i++) begin
      n_checks++;
      if (wr_log[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL stall_order[%0d]: got %0h want %0h", i, wr_log[i], i + 1); end
    end
    finish_frame("stall");
  endtask

  task automatic test_short();
    wr_log.delete();
    do_start(32'd6);
    send_range(1, 7, 7);
    n_checks++;
    if (err_short !== 1'b1) begin n_fail++; $display("FAIL short_pulse: got %b want 1", err_short); end
    n_checks++;
    if (words_written !== 32'd7) begin n_fail++; $display("FAIL short_words: got %0d want 7", words_written); end
    n_checks++;
    if ({busy, core_rs} !== 2'b00) begin n_fail++; $display("FAIL short_idle: busy/rs got %b want 00", {busy, core_rs}); end
    n_checks++;
    if (wr_log.size() != 7) begin n_fail++; $display("FAIL short_log_size: got %0d want 7", wr_log.size()); end
    tick();
    n_checks++;
    if (err_short !== 1'b0) begin n_fail++; $display("FAIL short_single_pulse: got %b want 0", err_short); end
  endtask

  task automatic test_clear_abort();
    do_start(32'd6);
    send_range(1, 2, 99);
    fifo_clear = 1'b1;
    tick();
    fifo_clear = 1'b0;
    n_checks++;
    if ({err_short, busy, core_rs} !== 3'b100) begin
      n_fail++; $display("FAIL clear_abort: short/busy/rs got %b want 100", {err_short, busy, core_rs});
    end
    n_checks++;
    if (words_written !== 32'd2) begin n_fail++; $display("FAIL clear_words: got %0d want 2", words_written); end
    tick();
  endtask

  task automatic test_long();
    wr_log.delete();
    do_start(32'd6);
    send_range(1, 10, 13);
    n_checks++;
    if (err_long !== 1'b1) begin n_fail++; $display("FAIL long_pulse: got %b want 1", err_long); end
    send_word(32'd11, 1'b0);
    n_checks++;
    if (err_long !== 1'b0) begin n_fail++; $display("FAIL long_single_pulse: got %b want 0", err_long); end
    send_range(12, 13, 13);
    n_checks++;
    if (words_written !== 32'd10) begin n_fail++; $display("FAIL long_words: got %0d want 10", words_written); end
    n_checks++;
    if (wr_log.size() != 10) begin n_fail++; $display("FAIL long_log_size: got %0d want 10", wr_log.size()); end
    n_checks++;
    if ({busy, s_axis_tready} !== 2'b10) begin n_fail++; $display("FAIL long_wait_core: busy/tready got %b want 10", {busy, s_axis_tready}); end
    fifo_clear = 1'b1;
    tick();
    fifo_clear = 1'b0;
    n_checks++;
    if ({busy, err_short} !== 2'b10) begin n_fail++; $display("FAIL long_clear_ignored: busy/short got %b want 10", {busy, err_short}); end
    finish_frame("long");
  endtask

  task automatic test_cfg_and_restart();
    do_start(32'd0);
    n_checks++;
    if ({err_cfg, busy} !== 2'b10) begin n_fail++; $display("FAIL cfg_pulse: cfg/busy got %b want 10", {err_cfg, busy}); end
    tick();
    n_checks++;
    if (err_cfg !== 1'b0) begin n_fail++; $display("FAIL cfg_single_pulse: got %b want 0", err_cfg); end
    do_start(32'd6);
    send_range(1, 2, 10);
    do_start(32'd2);
    n_checks++;
    if ({busy, err_cfg} !== 2'b10) begin n_fail++; $display("FAIL restart_ignored: busy/cfg got %b want 10", {busy, err_cfg}); end
    n_checks++;
    if (words_written !== 32'd2) begin n_fail++; $display("FAIL restart_words: got %0d want 2", words_written); end
    send_range(3, 10, 10);
    n_checks++;
    if (words_written !== 32'd10) begin n_fail++; $display("FAIL restart_reflen_kept: words got %0d want 10", words_written); end
    n_checks++;
    if ({busy, s_axis_tready} !== 2'b10) begin n_fail++; $display("FAIL restart_wait_core: busy/tready got %b want 10", {busy, s_axis_tready}); end
    finish_frame("restart");
  endtask

  task automatic test_reset_midframe();
    do_start(32'd6);
    send_range(1, 7, 99);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({core_rs, busy, frame_done, err_short, err_long, err_cfg} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_flags: rs/busy/done/short/long/cfg got %b want 000000",
               {core_rs, busy, frame_done, err_short, err_long, err_cfg});
    end
    n_checks++;
    if (words_written !== 32'd0) begin n_fail++; $display("FAIL midreset_words: got %0d want 0", words_written); end
    n_checks++;
    if ({s_axis_tready, fifo_wren} !== 2'b00) begin n_fail++; $display("FAIL midreset_stream: tready/wren got %b want 00", {s_axis_tready, fifo_wren}); end
    tick();
    wr_log.delete();
    do_start(32'd6);
    send_range(1, 10, 10);
    n_checks++;
    if (words_written !== 32'd10) begin n_fail++; $display("FAIL midreset_frame_words: got %0d want 10", words_written); end
    n_checks++;
    if (wr_log.size() != 10 || wr_log[0] !== 32'd1 || wr_log[wr_log.size()-1] !== 32'd10) begin
      n_fail++; $display("FAIL midreset_frame_log: size %0d want 10 with first 1 and last 10", wr_log.size());
    end
    finish_frame("midreset");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; reference_len = 32'd0;
    s_axis_tdata = 32'd0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    fifo_full = 1'b0; fifo_clear = 1'b0;
    core_running = 1'b0; core_done = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_short();
    test_clear_abort();
    test_long();
    test_cfg_and_restart();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dtw_src_writer.md
Name: dtw_src_writer

Overview:
Producer side of the DTW source FIFO. It accepts one AXI-Stream frame per search: SQG_LEN query words followed by reference_len reference words, with tlast on the final word. It writes each word into the source FIFO, starts the DTW core through rs/running, and reports frame completion or framing errors. It sits between the host DMA stream and the source FIFO that the DTW core controller drains.

Parameters:
SQG_LEN, 250, number of query words per frame; must be at least 1
DATA_W, 32, stream and FIFO word width

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
start  input  1  single-cycle pulse that arms one frame
reference_len  input  32  number of reference words; sampled on an accepted start
s_axis_tdata  input  DATA_W  stream data
s_axis_tvalid  input  1  stream valid
s_axis_tlast  input  1  last word of the frame
s_axis_tready  output  1  stream ready
fifo_wren  output  1  source FIFO write enable
fifo_wdata  output  DATA_W  source FIFO write data
fifo_full  input  1  source FIFO full
fifo_clear  input  1  clear request from the DTW core
core_rs  output  1  run/stop request to the DTW core
core_running  input  1  DTW core running flag
core_done  input  1  DTW core done flag
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse when the search completes
err_short  output  1  one-cycle pulse: tlast arrived early
err_long  output  1  one-cycle pulse: tlast missing on the final word
err_cfg  output  1  one-cycle pulse: start was received with reference_len == 0
words_written  output  32  number of FIFO writes in the current frame

Behaviour:
- Reset values: every registered output is 0 and the state is IDLE. This includes core_rs, busy, all pulse outputs and words_written. Reset mid-frame abandons the frame immediately; stream words still in flight are not drained.
- Transfer: xfer = s_axis_tvalid && s_axis_tready.
- s_axis_tready = (state is QUERY or REF) && !fifo_full, or state is FLUSH. It is combinational.
- fifo_wren = xfer && (state is QUERY or REF). fifo_wdata = s_axis_tdata. Both are combinational, so there is zero-cycle latency and a write can never reach a full FIFO.
- Counters: q_cnt counts query words and r_cnt counts reference words. Both are 32 bits, are cleared on an accepted start, and never wrap.
- words_written increments on each fifo_wren and is cleared on an accepted start.
- IDLE:
  - On start with reference_len != 0: latch ref_len, set core_rs=1, go to QUERY.
  - On start with reference_len == 0: pulse err_cfg and stay in IDLE.
- QUERY (accepts words, writes them to the FIFO):
  - On xfer with tlast=1: pulse err_short, clear core_rs, go to IDLE. The word is still written.
  - Otherwise, on xfer when q_cnt == SQG_LEN-1: go to REF.
- REF (accepts words, writes them to the FIFO):
  - On xfer with r_cnt == ref_len-1 and tlast=1: go to WAIT_CORE.
  - On xfer with r_cnt == ref_len-1 and tlast=0: pulse err_long, go to FLUSH.
  - On xfer with r_cnt < ref_len-1 and tlast=1: pulse err_short, clear core_rs, go to IDLE.
- FLUSH: accepts and discards words without writing them. On xfer with tlast: go to WAIT_CORE.
- WAIT_CORE: s_axis_tready=0. On core_done=1: pulse frame_done, go to IDLE.
- core_rs handshake: set on an accepted start. Cleared on the first cycle core_running is sampled 1, or on any return to IDLE. It is never reasserted within a frame.
- Ignored inputs:
  - start outside IDLE.
  - fifo_clear in IDLE and WAIT_CORE; it is the core's normal post-search clear.
- fifo_clear in QUERY, REF or FLUSH is an abort: pulse err_short, clear core_rs, go to IDLE. A word transferred in that same cycle is still written, but no state transition other than the abort happens.
- Simultaneous events:
  - fifo_full together with tvalid: no transfer occurs and all counters hold.
  - core_done on the same cycle the state enters WAIT_CORE: no effect; core_done is sampled only while already in WAIT_CORE.

Test Plan:
- SQG_LEN=4, ref_len=6, 10 words 0x1..0xA with tlast on 0xA, core_running high 3 cycles after start, core_done pulsed later:
  - FIFO receives 0x1..0xA in order.
  - words_written=10.
  - core_rs high from the cycle after start until the cycle after core_running rises.
  - One frame_done pulse, then IDLE.
- Same frame with fifo_full held high for 5 cycles after word 3:
  - tready=0 and no fifo_wren during the stall.
  - Words 4..10 are written afterward with no loss or duplication.
- SQG_LEN=4, ref_len=6, tlast on word 7:
  - err_short pulses on that cycle and words_written=7.
  - Returns to IDLE with core_rs=0.
- ref_len=6, 13 words with tlast on word 13:
  - err_long pulses at word 10.
  - Words 11..13 are accepted but not written; words_written=10.
  - Enters WAIT_CORE, then frame_done follows core_done.
- start with reference_len=0:
  - err_cfg pulses and busy stays 0.
  - A second start pulse mid-frame is ignored and the counters are unchanged.
- Assert rst during REF at r_cnt=3:
  - The next cycle shows every output at 0 and the state is IDLE.
  - A new start then completes a full frame normally.
